// File: rtl/mul_hash_pipe.sv
// mul_hash_pipe: multi-lane case-folding multiplicative hash with valid/ready flow control.
// Each lane computes product = (data & AND_MASK) * MULT mod 2^DATA_WIDTH through a
// sign-magnitude datapath, and extracts the top HASH_BITS of the product as the hash.
// Latency is 4 + MUL_STAGES cycles; a single stall (out_valid & ~out_ready) freezes the pipe.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_data/in_tag/in_valid   input beat (lane i at [i*DATA_WIDTH +: DATA_WIDTH]) and sideband tag
//   in_ready                  beat accepted this cycle when high (combinational, = ~stall)
//   out_product/out_hash      per-lane full product and product[DATA_WIDTH-1 -: HASH_BITS]
//   out_tag/out_valid         tag of the result beat and its valid
//   out_ready                 downstream accepts the result
// Optional macro MUL_HASH_PIPE_RUNTIME_MULT_EN adds cfg_mult/cfg_mult_wr: a runtime multiplier
// register that each beat samples at acceptance and carries down to the multiply stage.
module mul_hash_pipe #(
  parameter int unsigned           LANES      = 8,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           HASH_BITS  = 16,
  parameter logic [DATA_WIDTH-1:0] AND_MASK   = 64'hdfdfdfdfdfdfdfdf,
  parameter logic [DATA_WIDTH-1:0] MULT       = 64'h0b4e0ef37bc32127,
  parameter int unsigned           MUL_STAGES = 6,
  parameter int unsigned           TAG_WIDTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef MUL_HASH_PIPE_RUNTIME_MULT_EN
  input  logic [DATA_WIDTH-1:0]         cfg_mult,
  input  logic                          cfg_mult_wr,
`endif
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_product,
  output logic [LANES*HASH_BITS-1:0]    out_hash,
  output logic [TAG_WIDTH-1:0]          out_tag,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int unsigned LATENCY   = 4 + MUL_STAGES;
  // sign travels from the mask stage (2) to the product register stage (3+MUL_STAGES)
  localparam int unsigned SGN_DEPTH = MUL_STAGES + 2;

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  logic [DATA_WIDTH-1:0] d1_q   [LANES];
  logic [DATA_WIDTH-1:0] m2_q   [LANES];
  logic [DATA_WIDTH-1:0] mag_q  [MUL_STAGES][LANES];
  logic [DATA_WIDTH-1:0] prod_q [LANES];
  logic [LANES-1:0]      sgn_q  [SGN_DEPTH];
  logic [TAG_WIDTH-1:0]  tag_q  [LATENCY-1];
  logic [LATENCY-2:0]    vld_q;

  logic [DATA_WIDTH-1:0] mult_use;
  logic [DATA_WIDTH-1:0] prod_c [LANES];
  logic [DATA_WIDTH-1:0] res_c  [LANES];

`ifdef MUL_HASH_PIPE_RUNTIME_MULT_EN
  // Runtime multiplier; each beat captures it on acceptance (stage 1) and carries it to the multiply.
  logic [DATA_WIDTH-1:0] mult_q;
  logic [DATA_WIDTH-1:0] mlt_q [MUL_STAGES+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      mult_q <= MULT;
    end else if (cfg_mult_wr) begin
      mult_q <= cfg_mult;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < MUL_STAGES + 2; k++) mlt_q[k] <= MULT;
    end else if (!stall) begin
      mlt_q[0] <= mult_q;
      for (int unsigned k = 1; k < MUL_STAGES + 2; k++) mlt_q[k] <= mlt_q[k-1];
    end
  end

  assign mult_use = mlt_q[MUL_STAGES+1];
`else
  assign mult_use = MULT;
`endif

  // Multiply feeds the product register; final negate undoes the magnitude conversion.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      prod_c[l] = '0;
      res_c[l]  = '0;
      prod_c[l] = mag_q[MUL_STAGES-1][l] * mult_use;
      res_c[l]  = sgn_q[SGN_DEPTH-1][l] ? -prod_q[l] : prod_q[l];
    end
  end

  // Pipeline registers: everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_hash    <= '0;
      out_tag     <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        d1_q[l]   <= '0;
        m2_q[l]   <= '0;
        prod_q[l] <= '0;
        for (int unsigned k = 0; k < MUL_STAGES; k++) mag_q[k][l] <= '0;
      end
      for (int unsigned k = 0; k < SGN_DEPTH; k++) sgn_q[k] <= '0;
      for (int unsigned k = 0; k < LATENCY - 1; k++) tag_q[k] <= '0;
    end else if (!stall) begin
      vld_q     <= {vld_q[LATENCY-3:0], in_valid};
      out_valid <= vld_q[LATENCY-2];
      tag_q[0]  <= in_tag;
      for (int unsigned k = 1; k < LATENCY - 1; k++) tag_q[k] <= tag_q[k-1];
      out_tag   <= tag_q[LATENCY-2];
      for (int unsigned l = 0; l < LANES; l++) begin
        d1_q[l]      <= in_data[l*DATA_WIDTH +: DATA_WIDTH];
        m2_q[l]      <= d1_q[l] & AND_MASK;
        // sign is taken from the raw input bit, before masking
        sgn_q[0][l]  <= d1_q[l][DATA_WIDTH-1];
        mag_q[0][l]  <= sgn_q[0][l] ? -m2_q[l] : m2_q[l];
        for (int unsigned k = 1; k < MUL_STAGES; k++) mag_q[k][l] <= mag_q[k-1][l];
        prod_q[l]    <= prod_c[l];
        out_product[l*DATA_WIDTH +: DATA_WIDTH] <= res_c[l];
        out_hash[l*HASH_BITS +: HASH_BITS]      <= res_c[l][DATA_WIDTH-1 -: HASH_BITS];
      end
      for (int unsigned k = 1; k < SGN_DEPTH; k++) sgn_q[k] <= sgn_q[k-1];
    end
  end

endmodule

// File: doc/mul_hash_pipe.md
Name: mul_hash_pipe

Overview:
- Parametrised, multi-lane successor to the fixed 64-bit multiplicative hash stage in the Pigasus SME accelerator.
- Each lane computes a case-folding masked multiply hash of one input word: product = (data & AND_MASK) * MULT mod 2^DATA_WIDTH.
- Adds valid/ready flow control, a sideband tag, per-lane hash-bit extraction and a configurable multiplier pipeline depth.
- Sits between the byte-window extractor and the hash-table lookup stage.

Parameters:
- LANES, 8, number of independent hash lanes sharing one handshake.
- DATA_WIDTH, 64, input word and product width per lane.
- HASH_BITS, 16, width of hash output per lane; must satisfy 1 <= HASH_BITS <= DATA_WIDTH.
- AND_MASK, 64'hdfdfdfdfdfdfdfdf, case-folding mask applied to input; width DATA_WIDTH.
- MULT, 64'h0b4e0ef37bc32127, multiplier constant; width DATA_WIDTH; must be odd.
- MUL_STAGES, 6, register stages allotted to the multiplier (retiming slack); must be >= 1.
- TAG_WIDTH, 8, sideband tag width carried alongside data.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_tag  in  TAG_WIDTH  sideband, returned unchanged with the result.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- out_product  out  LANES*DATA_WIDTH  full DATA_WIDTH-bit product per lane.
- out_hash  out  LANES*HASH_BITS  per-lane product[DATA_WIDTH-1 -: HASH_BITS].
- out_tag  out  TAG_WIDTH  tag of the accepted beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Function per lane:
  - m = in & AND_MASK.
  - product = m*MULT mod 2^DATA_WIDTH.
  - Internally computed as sign-magnitude: s = in[DATA_WIDTH-1] before masking; magnitude = s ? -m : m; result = s ? -(magnitude*MULT) : magnitude*MULT. All operations are mod 2^DATA_WIDTH.
  - The result is bit-identical to the unsigned form.
- Pipeline:
  - Stage 1: input register.
  - Stage 2: mask and sign capture.
  - Stage 3: conditional negate.
  - Stages 4..3+MUL_STAGES: multiply. The product is registered at the last multiply stage; the remaining stages are balancing registers.
  - Final stage: conditional negate, hash extraction, output register.
- Latency: LATENCY = 4 + MUL_STAGES cycles from accepted beat to out_valid, with no stall. Default is 10.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - A beat is accepted when in_valid & in_ready.
  - When stall is high, every pipeline register, including valid, sign and tag shift registers, holds its value.
  - Throughput is 1 beat per cycle when out_ready stays high.
- Valid tracking: 1-bit valid shift register of depth LATENCY. Bubbles (in_valid low while not stalled) propagate as invalid slots. Data registers of invalid slots are don't-care, but the outputs of an invalid slot must not be presented as valid.
- Output holding: while out_valid & ~out_ready, out_product, out_hash and out_tag are held stable.
- Reset:
  - All valid bits clear.
  - out_valid = 0, out_product = 0, out_hash = 0, out_tag = 0.
  - in_ready = 1 on the first cycle after reset.
  - Reset mid-operation discards all in-flight beats; no result from before reset may appear after it.
- Simultaneous accept and emit in one cycle is the normal steady state; there are no ordering hazards.
- Ordering: results emerge strictly in acceptance order.

Optional Feature:
- Macro: MUL_HASH_PIPE_RUNTIME_MULT_EN.
- Defined: adds ports cfg_mult (in, DATA_WIDTH) and cfg_mult_wr (in, 1).
  - A register mult_q replaces MULT. It resets to MULT and loads cfg_mult on cycles where cfg_mult_wr = 1.
  - The new value applies to beats accepted on or after the cycle following the write. In-flight beats use the multiplier sampled at their acceptance; each beat carries its multiplier down the pipe to the multiply stage.
  - If cfg_mult is even, it is still loaded; no error is flagged.
- Undefined: no extra ports, and the multiplier is the constant MULT.

Test Plan:
- Constant inputs, out_ready = 1. All defaults throughout.
  - Lane 0 = 0x0000000000000001 -> out_product = 0x0b4e0ef37bc32127, out_hash = 0x0b4e, exactly 10 cycles after accept.
  - Lane 0 = 0x0000000000000002 -> out_product = 0x169c1de6f786424e, out_hash = 0x169c.
- Mask and sign path:
  - Lane input 0x2020202020202020 -> out_product = 0.
  - Lane input 0x8000000000000000 -> out_product = 0x8000000000000000, out_hash = 0x8000.
- Back-to-back stream:
  - Stimulus: 20 consecutive beats with tags 0..19 and random data, out_ready = 1.
  - Required: 20 consecutive out_valid cycles, tags in order, every lane matching the (in & AND_MASK)*MULT model.
- Backpressure:
  - Stimulus: out_ready = 0 for 5 cycles while results are pending.
  - Required: in_ready = 0 while stalled, outputs stable, no beat lost or duplicated; on out_ready = 1 the stream resumes in order.
- Reset mid-flight:
  - Stimulus: accept 4 beats, assert rst for 1 cycle 3 cycles later.
  - Required: out_valid stays 0 for 10 cycles after reset release, and in_ready = 1.
- MUL_HASH_PIPE_RUNTIME_MULT_EN defined:
  - Stimulus: write cfg_mult = 3, then send lane input 5 the next cycle.
  - Required: out_product = 15; beats accepted before the write still use 0x0b4e0ef37bc32127.
